dot_prod_sched: RTL and testbench
=================================

Name: dot_prod_sched

Overview:
- Job scheduler and memory-ownership controller in front of the dot-product engine.
- Queues dot-product jobs (start index, chain flag) and launches each on the engine with an `r_enable` pulse.
- Captures the engine's `result` on `w_enable` and returns it over a valid/ready port.
- Arbitrates the shared operand RAMs (`controlArr` ports a/b) between the host loader and the engine, so the host never writes while the engine reads.

Parameters:
- ADDR_W, 10, width of engine start index (init_i)
- ACC_W, 64, width of accumulator/result (signed)
- QDEPTH, 4, job FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job request valid
- job_ready  out  1  job FIFO not full
- job_start  in  ADDR_W  engine start index
- job_chain  in  1  1: init_acc = previous job's result; 0: init_acc = 0
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  ACC_W  signed job result
- host_req  in  1  host requests operand-RAM write access
- host_grant  out  1  host may drive RAM write ports this cycle
- eng_control_arr  out  1  RAM owner: 1 = host side, 0 = engine
- eng_r_enable  out  1  engine start pulse
- eng_init_i  out  ADDR_W  engine start index
- eng_init_acc  out  ACC_W  signed engine initial accumulator
- eng_w_enable  in  1  engine done strobe
- eng_result  in  ACC_W  signed engine result
- busy  out  1  state is LAUNCH or RUN

Behaviour:
- Reset values: job_ready=1, res_valid=0, res_data=0, host_grant=0, eng_control_arr=1, eng_r_enable=0, eng_init_i=0, eng_init_acc=0, busy=0.
- Reset also: FIFO emptied, last_result=0, last_served=JOB, state=IDLE.
- Reset mid-operation aborts everything the same way; eng_w_enable after reset is ignored unless state is RUN.
- FIFO:
  - Push on job_valid&&job_ready; job_ready = !full (registered count).
  - Pop only on entry to LAUNCH.
  - Simultaneous push and pop allowed when full-1 or less; count unchanged.
- FSM states: IDLE, HOST, LAUNCH, RUN, RESP.
- IDLE:
  - Host wins if host_req && (FIFO empty || last_served==JOB) → HOST.
  - Else if FIFO non-empty → LAUNCH. This gives round-robin under contention.
  - Else stay.
- HOST:
  - host_grant=1, eng_control_arr=1.
  - Stay while host_req=1. On host_req=0 → IDLE; host_grant drops that same edge.
  - Set last_served=HOST.
- LAUNCH (exactly 1 cycle):
  - eng_r_enable=1, eng_control_arr=0.
  - eng_init_i=head.start; eng_init_acc = head.chain ? last_result : 0.
  - Pop FIFO, last_served=JOB → RUN.
- RUN:
  - eng_control_arr=0, eng_r_enable=0; eng_init_i/eng_init_acc held stable.
  - When eng_w_enable sampled at edge M: res_data<=eng_result, last_result<=eng_result → RESP.
  - No timeout.
- RESP:
  - res_valid=1, eng_control_arr=1, res_data stable until res_ready.
  - On res_valid&&res_ready → IDLE.
- Latency:
  - Job pushed into empty FIFO at edge N, no host_req, state IDLE → eng_r_enable high between edges N+1 and N+2.
  - w_enable at edge M → res_valid high from edge M.
  - Minimum job-to-job launch spacing: RESP + IDLE = 2 cycles.
- Invariants:
  - host_grant and eng_control_arr=0 never both true.
  - eng_r_enable is only a single-cycle pulse.
  - eng_w_enable outside RUN is ignored.
- Arithmetic: no computation on results; signed values passed through at ACC_W width. Chaining uses last completed result only.

Optional Feature:
- DOT_PROD_SCHED_PERF_EN
- Defined:
  - Adds output perf_cycles [31:0].
  - Counts cycles from the LAUNCH cycle through the cycle eng_w_enable is sampled, inclusive.
  - Latched into perf_cycles with res_data and valid while res_valid; saturates at 2^32-1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles mid-traffic → all outputs at reset values next edge; FIFO empty, job_ready=1.
- Single job: start=0, chain=0; engine model asserts w_enable 5 cycles after r_enable with result=42.
  - Expect one-cycle r_enable with init_i=0, init_acc=0, eng_control_arr=0.
  - Expect res_data=42 held until res_ready; perf_cycles=6 when enabled.
- Chaining: job A start=0 returns -100, then job B start=500 chain=1 → B launches with init_acc=-100, init_i=500. Job C chain=0 → init_acc=0.
- Back-pressure: res_ready=0, engine stalled, push jobs continuously → exactly QDEPTH+1 accepted (one in flight), then job_ready=0 until a pop.
- Contention: host_req=1 with 2 queued jobs after a job completes → order HOST, JOB, HOST(if still requested), JOB. host_grant never high while eng_control_arr=0.
- Reset in RUN: rst pulse while engine running, then stray w_enable=1 with result=7 → no res_valid, FIFO empty, last_result=0 (next chain job gets init_acc=0).

Source files
------------

// File: rtl/dot_prod_sched.sv
// rtl/dot_prod_sched.sv - job scheduler and operand-RAM ownership controller for the dot-product engine
// Optional build macro: DOT_PROD_SCHED_PERF_EN adds the perf_cycles output (launch-to-done cycle count).
module dot_prod_sched #(
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [ADDR_W-1:0]        job_start,
    input  logic                     job_chain,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    input  logic                     host_req,
    output logic                     host_grant,
    output logic                     eng_control_arr,
    output logic                     eng_r_enable,
    output logic [ADDR_W-1:0]        eng_init_i,
    output logic signed [ACC_W-1:0]  eng_init_acc,
    input  logic                     eng_w_enable,
    input  logic signed [ACC_W-1:0]  eng_result,
    output logic                     busy
`ifdef DOT_PROD_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_LAUNCH,
        S_RUN,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]       q_start [QDEPTH];
    logic                    q_chain [QDEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    fifo_empty;
    logic                    push, pop, launch;
    logic                    last_served_host;
    logic signed [ACC_W-1:0] last_result;
    logic                    done;

    assign fifo_empty = (count == '0);
    assign job_ready  = (count != CNT_W'(QDEPTH));
    assign push       = job_valid && job_ready;
    assign pop        = launch;
    assign done       = (state == S_RUN) && eng_w_enable;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and per-state outputs; host wins in IDLE only if the engine was served last
    always_comb begin
        state_next      = state;
        launch          = 1'b0;
        host_grant      = 1'b0;
        eng_control_arr = 1'b1;
        eng_r_enable    = 1'b0;
        res_valid       = 1'b0;
        busy            = 1'b0;
        case (state)
            S_IDLE: begin
                if (host_req && (fifo_empty || !last_served_host)) begin
                    state_next = S_HOST;
                end else if (!fifo_empty) begin
                    state_next = S_LAUNCH;
                    launch     = 1'b1;
                end
            end
            S_HOST: begin
                host_grant = 1'b1;
                if (!host_req) state_next = S_IDLE;
            end
            S_LAUNCH: begin
                eng_r_enable    = 1'b1;
                eng_control_arr = 1'b0;
                busy            = 1'b1;
                state_next      = S_RUN;
            end
            S_RUN: begin
                eng_control_arr = 1'b0;
                busy            = 1'b1;
                if (eng_w_enable) state_next = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Job FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            q_start[wr_ptr] <= job_start;
            q_chain[wr_ptr] <= job_chain;
        end
    end

    // Job FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch parameters captured from the FIFO head as the job is popped, held through RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_init_i       <= '0;
            eng_init_acc     <= '0;
            last_served_host <= 1'b0;
        end else begin
            if (launch) begin
                eng_init_i       <= q_start[rd_ptr];
                eng_init_acc     <= q_chain[rd_ptr] ? last_result : '0;
                last_served_host <= 1'b0;
            end else if (state == S_HOST) begin
                last_served_host <= 1'b1;
            end
        end
    end

    // Result capture; a done strobe outside RUN is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data    <= '0;
            last_result <= '0;
        end else if (done) begin
            res_data    <= eng_result;
            last_result <= eng_result;
        end
    end

`ifdef DOT_PROD_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_inc;

    assign perf_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

    // Saturating launch-to-done counter; the LAUNCH cycle and the done cycle are both counted
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (launch) begin
                perf_cnt <= '0;
            end else if (state == S_LAUNCH || state == S_RUN) begin
                perf_cnt <= perf_inc;
            end
            if (done) perf_cycles <= perf_inc;
        end
    end
`endif

endmodule

// File: tb/tb_dot_prod_sched.sv
// tb/tb_dot_prod_sched.sv - scoreboard bench for dot_prod_sched with a behavioural engine model
module tb_dot_prod_sched;

    localparam int ADDR_W = 10;
    localparam int ACC_W  = 64;
    localparam int QDEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    job_valid;
    logic                    job_ready;
    logic [ADDR_W-1:0]       job_start;
    logic                    job_chain;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;
    logic                    host_req;
    logic                    host_grant;
    logic                    eng_control_arr;
    logic                    eng_r_enable;
    logic [ADDR_W-1:0]       eng_init_i;
    logic signed [ACC_W-1:0] eng_init_acc;
    logic                    eng_w_enable;
    logic signed [ACC_W-1:0] eng_result;
    logic                    busy;
`ifdef DOT_PROD_SCHED_PERF_EN
    logic [31:0]             perf_cycles;
`endif

    dot_prod_sched #(.ADDR_W(ADDR_W), .ACC_W(ACC_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_start(job_start), .job_chain(job_chain),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .host_req(host_req), .host_grant(host_grant),
        .eng_control_arr(eng_control_arr), .eng_r_enable(eng_r_enable),
        .eng_init_i(eng_init_i), .eng_init_acc(eng_init_acc),
        .eng_w_enable(eng_w_enable), .eng_result(eng_result),
        .busy(busy)
`ifdef DOT_PROD_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    typedef struct packed {
        logic              chain;
        logic [ADDR_W-1:0] start;
    } job_t;

    int tests = 0;
    int fails = 0;

    // Reference model: jobs in issue order, results/perf in completion order, last completed result
    job_t                    jobq[$];
    logic signed [ACC_W-1:0] exp_res[$];
    int unsigned             exp_perf[$];
    logic signed [ACC_W-1:0] model_last;

    bit                      eng_stall;
    bit                      eng_active;
    bit                      stray_req;
    bit                      rand_bg;
    bit                      log_en;
    string                   order_log;
    int                      dir_delay[$];
    logic signed [ACC_W-1:0] dir_res[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Engine model: checks launch parameters, returns a result after a chosen number of cycles
    initial begin : engine
        int k;
        int d;
        job_t j;
        logic signed [ACC_W-1:0] r;
        eng_w_enable = 1'b0;
        eng_result   = '0;
        eng_active   = 1'b0;
        k = 0;
        d = 0;
        forever begin
            @(negedge clk);
            eng_w_enable = 1'b0;
            if (rst) begin
                eng_active = 1'b0;
            end else begin
                if (stray_req) begin
                    eng_w_enable = 1'b1;
                    eng_result   = 64'sd7;
                    stray_req    = 1'b0;
                end
                if (eng_r_enable) begin
                    if (jobq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL launch_unexpected: got launch of %0d expected none", eng_init_i);
                    end else begin
                        j = jobq.pop_front();
                        check("launch_init_i", 64'(eng_init_i), 64'(j.start));
                        check("launch_init_acc", eng_init_acc, j.chain ? model_last : 64'sd0);
                        check("launch_owner", 64'(eng_control_arr), 64'd0);
                    end
                    eng_active = 1'b1;
                    k = 0;
                    d = (dir_delay.size() != 0) ? dir_delay.pop_front() : int'($urandom_range(1, 8));
                end else if (eng_active) begin
                    k++;
                    if (k >= d && !eng_stall) begin
                        r = (dir_res.size() != 0) ? dir_res.pop_front() : {$urandom, $urandom};
                        eng_w_enable = 1'b1;
                        eng_result   = r;
                        exp_res.push_back(r);
                        exp_perf.push_back(k + 1);
                        model_last = r;
                        eng_active = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pop on result handshake plus per-cycle ownership invariants
    initial begin : monitor
        logic prev_r;
        logic prev_valid;
        logic prev_g;
        logic signed [ACC_W-1:0] prev_data;
        int unsigned p;
        prev_r = 1'b0;
        prev_valid = 1'b0;
        prev_g = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_r = 1'b0;
                prev_valid = 1'b0;
                prev_g = 1'b0;
            end else begin
                check("grant_vs_owner", 64'(host_grant && !eng_control_arr), 64'd0);
                if (prev_r) check("r_enable_pulse", 64'(eng_r_enable), 64'd0);
                if (prev_valid && res_valid) check("res_hold", res_data, prev_data);
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL res_unexpected: got %0d expected no result", res_data);
                    end else begin
                        check("res_data", res_data, exp_res.pop_front());
                        p = exp_perf.pop_front();
`ifdef DOT_PROD_SCHED_PERF_EN
                        check("perf_cycles", 64'(perf_cycles), 64'(p));
`endif
                    end
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = res_valid;
                    prev_data  = res_data;
                end
                if (log_en) begin
                    if (host_grant && !prev_g) order_log = {order_log, "H"};
                    if (eng_r_enable) order_log = {order_log, "J"};
                end
                prev_r = eng_r_enable;
                prev_g = host_grant;
            end
        end
    end

    // Background randomisation of consumer back-pressure and host requests
    initial begin : background
        forever begin
            @(posedge clk);
            #1;
            if (rand_bg) begin
                res_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) host_req = ~host_req;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(string tag);
        check({tag, "_job_ready"},  64'(job_ready), 64'd1);
        check({tag, "_res_valid"},  64'(res_valid), 64'd0);
        check({tag, "_res_data"},   res_data, 64'd0);
        check({tag, "_host_grant"}, 64'(host_grant), 64'd0);
        check({tag, "_owner"},      64'(eng_control_arr), 64'd1);
        check({tag, "_r_enable"},   64'(eng_r_enable), 64'd0);
        check({tag, "_init_i"},     64'(eng_init_i), 64'd0);
        check({tag, "_init_acc"},   eng_init_acc, 64'd0);
        check({tag, "_busy"},       64'(busy), 64'd0);
`ifdef DOT_PROD_SCHED_PERF_EN
        check({tag, "_perf"},       64'(perf_cycles), 64'd0);
`endif
    endtask

    task automatic push_job(input logic [ADDR_W-1:0] s, input logic c);
        int t;
        job_t j;
        @(posedge clk);
        #1;
        job_valid = 1'b1;
        job_start = s;
        job_chain = c;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!job_ready && t < 300);
        tests++;
        if (!job_ready) begin
            fails++;
            $display("FAIL push_timeout: got job_ready=0 expected 1");
        end else begin
            j.chain = c;
            j.start = s;
            jobq.push_back(j);
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    // which: 0 = res_valid, 1 = host_grant, 2 = busy
    task automatic wait_for(input int which, input string name);
        int t;
        logic v;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            v = (which == 0) ? res_valid : (which == 1) ? host_grant : busy;
        end while (!v && t < 300);
        check(name, 64'(v), 64'd1);
    endtask

    task automatic wait_idle(input int bound);
        int t;
        logic ok;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            ok = (jobq.size() == 0) && (exp_res.size() == 0) && !eng_active && !busy && !res_valid;
        end while (!ok && t < bound);
        check("drain", 64'(ok), 64'd1);
    endtask

    initial begin : main
        int acc;
        rst = 1'b1;
        job_valid = 1'b0;
        job_start = '0;
        job_chain = 1'b0;
        res_ready = 1'b0;
        host_req = 1'b0;
        eng_stall = 1'b0;
        stray_req = 1'b0;
        rand_bg = 1'b0;
        log_en = 1'b0;
        order_log = "";
        model_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single job: result 42 after 5 cycles, held under back-pressure
        dir_delay.push_back(5);
        dir_res.push_back(64'sd42);
        push_job(10'd0, 1'b0);
        @(negedge clk);
        check("lat_idle", 64'(eng_r_enable), 64'd0);
        @(negedge clk);
        check("lat_launch", 64'(eng_r_enable), 64'd1);
        wait_for(0, "single_res_valid");
        check("single_res_42", res_data, 64'sd42);
        repeat (3) @(negedge clk);
        check("single_still_valid", 64'(res_valid), 64'd1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_idle(200);

        // Chaining: A -> -100, B chains it, C does not
        dir_res.push_back(-64'sd100);
        push_job(10'd0, 1'b0);
        push_job(10'd500, 1'b1);
        push_job(10'd7, 1'b0);
        wait_idle(300);

        // Back-pressure: stalled engine and consumer, FIFO plus one in flight
        res_ready = 1'b0;
        eng_stall = 1'b1;
        acc = 0;
        @(posedge clk);
        #1;
        job_valid = 1'b1;
        job_start = ADDR_W'($urandom);
        job_chain = 1'($urandom);
        repeat (20) begin
            @(negedge clk);
            if (job_ready) begin
                jobq.push_back({job_chain, job_start});
                acc++;
            end
            @(posedge clk);
            #1;
            job_start = ADDR_W'($urandom);
            job_chain = 1'($urandom);
        end
        job_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(QDEPTH + 1));
        @(negedge clk);
        check("bp_job_ready", 64'(job_ready), 64'd0);
        eng_stall = 1'b0;
        res_ready = 1'b1;
        wait_idle(500);

        // Contention: host and two queued jobs alternate
        res_ready = 1'b0;
        push_job(ADDR_W'($urandom), 1'b0);
        wait_for(0, "cont_first_done");
        push_job(ADDR_W'($urandom), 1'b1);
        push_job(ADDR_W'($urandom), 1'b0);
        order_log = "";
        log_en = 1'b1;
        host_req = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_for(1, "cont_grant1");
        repeat (3) @(posedge clk);
        #1;
        host_req = 1'b0;
        @(posedge clk);
        #1;
        host_req = 1'b1;
        wait_for(1, "cont_grant2");
        repeat (2) @(posedge clk);
        #1;
        host_req = 1'b0;
        wait_idle(300);
        log_en = 1'b0;
        tests++;
        if (order_log != "HJHJ") begin
            fails++;
            $display("FAIL cont_order: got %s expected HJHJ", order_log);
        end

        // Reset while RUN, then a stray done strobe
        eng_stall = 1'b1;
        push_job(ADDR_W'($urandom), 1'b0);
        wait_for(2, "rr_busy");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        jobq.delete();
        exp_res.delete();
        exp_perf.delete();
        model_last = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        eng_stall = 1'b0;
        stray_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rr_no_valid", 64'(res_valid), 64'd0);
            check("rr_idle", 64'(busy), 64'd0);
        end
        push_job(10'd5, 1'b1);
        wait_idle(200);

        // Randomised traffic with host contention and consumer back-pressure
        rand_bg = 1'b1;
        repeat (40) begin
            push_job(ADDR_W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_bg = 1'b0;
        @(posedge clk);
        #1;
        host_req = 1'b0;
        res_ready = 1'b1;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
